// File: rtl/cog_ram_2p.sv
// cog_ram_2p: single-clock true dual-port RAM with byte-lane write enables,
// a 1- or 2-stage read pipeline and a post-reset clear sequencer.
// The array is split into one byte-wide lane slice per write-enable bit.

// One byte lane of the array. It holds storage and the per-port
// write-first merge for this lane.
module cog_ram_2p_lane #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] ca,
  input  logic          wea,
  input  logic          web,
  input  logic          owb,
  input  logic [AW-1:0] aa,
  input  logic [AW-1:0] ab,
  input  logic [7:0]    da,
  input  logic [7:0]    db,
  output logic [7:0]    ra,
  output logic [7:0]    rb
);
  logic [7:0] mem [1<<AW];

  // Clear has priority. web is pre-masked by the top when A owns this byte,
  // so the two port writes never land on the same cell.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem[ca] <= '0;
    end else begin
      if (wea) mem[aa] <= da;
      if (web) mem[ab] <= db;
    end
  end

  // Same-port write-first. Each port sees the pre-edge array for the other
  // port's write, which gives read-first behaviour across ports. B's merge
  // uses its own strobe, not the collision-masked one.
  assign ra = wea ? da : mem[aa];
  assign rb = owb ? db : mem[ab];
endmodule

module cog_ram_2p #(
  parameter int DW     = 32,
  parameter int AW     = 9,
  parameter int RD_LAT = 1,
  parameter int CLR_EN = 1
) (
  input  logic            clk,
  input  logic            nres,
  input  logic            ena,
  input  logic            wa,
  input  logic [DW/8-1:0] bea,
  input  logic [AW-1:0]   aa,
  input  logic [DW-1:0]   da,
  output logic [DW-1:0]   qa,
  input  logic            enb,
  input  logic            wb,
  input  logic [DW/8-1:0] beb,
  input  logic [AW-1:0]   ab,
  input  logic [DW-1:0]   db,
  output logic [DW-1:0]   qb,
  output logic            busy,
  output logic            coll
);
  localparam int NB = DW / 8;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          rdy, acc_a, acc_b, wr_a, wr_b, same;
  logic [NB-1:0] own_a, own_b, lane_b;
  logic [DW-1:0] rd_a, rd_b;

  // Sequencer state and clear address. Reset re-arms the clear.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state <= (CLR_EN != 0) ? S_CLEAR : S_READY;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Step through every address once. Leave CLEAR after the last write.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (&cnt) state_nx = S_READY;
      end
      default: ;
    endcase
  end

  assign busy  = (state == S_CLEAR);
  assign rdy   = (state == S_READY);
  assign acc_a = ena & rdy;
  assign acc_b = enb & rdy;
  assign wr_a  = acc_a & wa;
  assign wr_b  = acc_b & wb;
  assign same  = (aa == ab);
  assign own_a = {NB{wr_a}} & bea;
  assign own_b = {NB{wr_b}} & beb;
  // On a same-address collision, A keeps the shared lanes. B still writes
  // the rest.
  assign lane_b = own_b & ~({NB{same}} & own_a);

  for (genvar g = 0; g < NB; g++) begin : g_lane
    cog_ram_2p_lane #(.AW(AW)) u_lane (
      .clk (clk),
      .clr (busy),
      .ca  (cnt),
      .wea (own_a[g]),
      .web (lane_b[g]),
      .owb (own_b[g]),
      .aa  (aa),
      .ab  (ab),
      .da  (da[g*8 +: 8]),
      .db  (db[g*8 +: 8]),
      .ra  (rd_a[g*8 +: 8]),
      .rb  (rd_b[g*8 +: 8])
    );
  end

  if (RD_LAT == 1) begin : g_lat1
    // A single output register loads on an accepted access and holds
    // otherwise.
    always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
        qa <= '0;
        qb <= '0;
      end else begin
        if (acc_a) qa <= rd_a;
        if (acc_b) qb <= rd_b;
      end
    end
  end else begin : g_lat2
    logic [DW-1:0] s_a, s_b;
    logic [1:0]    vld_pipe_a, vld_pipe_b;

    assign vld_pipe_a[0] = acc_a;
    assign vld_pipe_b[0] = acc_b;

    // Two stages. The output stage advances only when stage 1 captured a
    // read on the previous edge, so idle cycles hold both stages.
    always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
        s_a           <= '0;
        s_b           <= '0;
        qa            <= '0;
        qb            <= '0;
        vld_pipe_a[1] <= 1'b0;
        vld_pipe_b[1] <= 1'b0;
      end else begin
        vld_pipe_a[1] <= vld_pipe_a[0];
        vld_pipe_b[1] <= vld_pipe_b[0];
        if (vld_pipe_a[0]) s_a <= rd_a;
        if (vld_pipe_b[0]) s_b <= rd_b;
        if (vld_pipe_a[1]) qa  <= s_a;
        if (vld_pipe_b[1]) qb  <= s_b;
      end
    end
  end

  // Collision debug pulse: both ports wrote one word with shared lanes.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) coll <= 1'b0;
    else       coll <= wr_a & wr_b & same & (|(bea & beb));
  end
endmodule
